// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: parallel PRBS7/15/23/31 word generator with error injection, and a
// self-synchronising checker (SEARCH -> CHECK -> LOCKED) with a saturating bit-error count.
module prbs_gen_chk #(
  parameter int W      = 8,
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 16,
  parameter int LOSS_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             gen_en,
  input  logic             inj_err,
  output logic [W-1:0]     gen_data,
  output logic             gen_valid,
  input  logic             chk_valid,
  input  logic [W-1:0]     chk_data,
  input  logic             err_clr,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic             word_err
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int LW = $clog2(LOSS_N + 1);
  localparam int SW = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  typedef struct packed {
    logic [30:0]  s;
    logic [W-1:0] w;
  } step_t;

  // Feedback bit s[n-1]^s[t-1] of the selected polynomial.
  function automatic logic feedback(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return s[6]  ^ s[5];
      2'd1:    return s[14] ^ s[13];
      2'd2:    return s[22] ^ s[17];
      default: return s[30] ^ s[27];
    endcase
  endfunction

  // Polynomial order n of the selected mode.
  function automatic logic [6:0] order(input logic [1:0] m);
    case (m)
      2'd0:    return 7'd7;
      2'd1:    return 7'd15;
      2'd2:    return 7'd23;
      default: return 7'd31;
    endcase
  endfunction

  // Runs the LFSR W bits; the first bit produced lands on bit 0 of the word.
  function automatic step_t lfsr_word(input logic [30:0] s, input logic [1:0] m);
    step_t r;
    logic  b;
    r.s = s;
    r.w = '0;
    for (int i = 0; i < W; i++) begin
      // NOTE: blocking '=' is intended here: each bit must see the state left by the previous one.
      b   = feedback(r.s, m);
      r.s = {r.s[29:0], b};
      r.w = W'({b, r.w} >> 1);
    end
    return r;
  endfunction

  // Shifts a received word into the LFSR, bit 0 first.
  function automatic logic [30:0] shift_in(input logic [30:0] s, input logic [W-1:0] d);
    logic [30:0]  r;
    logic [W-1:0] x;
    r = s;
    x = d;
    for (int i = 0; i < W; i++) begin
      r = {r[29:0], x[0]};
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic logic [5:0] popcount(input logic [W-1:0] d);
    logic [5:0]   p;
    logic [W-1:0] x;
    p = '0;
    x = d;
    for (int i = 0; i < W; i++) begin
      p = p + 6'(x[0]);
      x = x >> 1;
    end
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [SW-1:0] v);
    return (v > SW'(CNT_MAX)) ? CNT_MAX : v[CNT_W-1:0];
  endfunction

  logic [30:0]   gen_s;
  logic [30:0]   chk_s;
  logic [1:0]    mode_q;
  state_t        state;
  logic [6:0]    load_cnt;
  logic [GW-1:0] good_cnt;
  logic [LW-1:0] loss_cnt;

  step_t       gen_step;
  step_t       pred;
  logic [30:0] loaded;
  logic [W-1:0] diff;
  logic [5:0]  pop;
  logic        mismatch;
  logic        mode_chg;
  logic        count_err;

  assign gen_step  = lfsr_word(gen_s, mode);
  assign pred      = lfsr_word(chk_s, mode);
  assign loaded    = shift_in(chk_s, chk_data);
  assign diff      = pred.w ^ chk_data;
  assign pop       = popcount(diff);
  assign mismatch  = |diff;
  assign mode_chg  = (mode != mode_q);
  assign count_err = chk_valid && (state == LOCKED) && !mode_chg && mismatch;

  // Remember the previous mode so any change restarts generator and checker.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    mode_q <= mode;
  end

  // Generator: one registered word per gen_en, bit 0 optionally inverted on output only.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_s     <= '1;
      gen_data  <= '0;
      gen_valid <= 1'b0;
    end else if (mode_chg) begin
      gen_s     <= '1;
      gen_valid <= 1'b0;
    end else if (gen_en) begin
      gen_s     <= gen_step.s;
      gen_data  <= gen_step.w ^ W'(inj_err);
      gen_valid <= 1'b1;
    end else begin
      gen_valid <= 1'b0;
    end
  end

  // Checker: state machine, lock/loss counting and saturating error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_s    <= '1;
      state    <= SEARCH;
      load_cnt <= '0;
      good_cnt <= '0;
      loss_cnt <= '0;
      locked   <= 1'b0;
      word_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      word_err <= 1'b0;
      if (err_clr)        err_cnt <= count_err ? sat(SW'(pop)) : '0;
      else if (count_err) err_cnt <= sat(SW'(err_cnt) + SW'(pop));

      if (mode_chg) begin
        chk_s    <= '1;
        state    <= SEARCH;
        load_cnt <= '0;
        good_cnt <= '0;
        loss_cnt <= '0;
        locked   <= 1'b0;
      end else if (chk_valid) begin
        unique case (state)
          SEARCH: begin
            chk_s <= loaded;
            if ((load_cnt + 7'(W)) >= order(mode)) begin
              state    <= CHECK;
              load_cnt <= '0;
              good_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + 7'(W);
            end
          end
          CHECK: begin
            chk_s    <= loaded;
            word_err <= mismatch;
            if (mismatch) begin
              state    <= SEARCH;
              good_cnt <= '0;
              load_cnt <= '0;
            end else if (good_cnt == GW'(LOCK_N - 1)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
              loss_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
          LOCKED: begin
            chk_s    <= pred.s;
            word_err <= mismatch;
            if (!mismatch) begin
              loss_cnt <= '0;
            end else if (loss_cnt == LW'(LOSS_N - 1)) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              loss_cnt <= '0;
              load_cnt <= '0;
            end else begin
              loss_cnt <= loss_cnt + LW'(1);
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: directed bench for prbs_gen_chk; a default instance in loopback and a
// CNT_W=4 instance for counter saturation and clear behaviour.
module tb_prbs_gen_chk;

  localparam int ORD  [4] = '{7, 15, 23, 31};
  localparam int TAP  [4] = '{6, 14, 18, 28};
  localparam int LOCKW[4] = '{17, 18, 19, 20};

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        gen_en;
  logic        inj_err;
  logic [7:0]  gen_data;
  logic        gen_valid;
  logic        chk_valid;
  logic [7:0]  chk_data;
  logic        err_clr;
  logic        locked;
  logic [15:0] err_cnt;
  logic        word_err;
  logic        force_ff;

  logic        s_inj_err;
  logic [7:0]  s_gen_data;
  logic        s_gen_valid;
  logic        s_chk_valid;
  logic [7:0]  s_chk_data;
  logic        s_err_clr;
  logic        s_locked;
  logic [3:0]  s_err_cnt;
  logic        s_word_err;
  logic [7:0]  s_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign chk_data    = force_ff ? 8'hFF : gen_data;
  assign chk_valid   = gen_valid;
  assign s_chk_data  = s_gen_data ^ s_mask;
  assign s_chk_valid = s_gen_valid;

  prbs_gen_chk #(.W(8), .CNT_W(16), .LOCK_N(16), .LOSS_N(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .gen_en(gen_en), .inj_err(inj_err),
    .gen_data(gen_data), .gen_valid(gen_valid), .chk_valid(chk_valid),
    .chk_data(chk_data), .err_clr(err_clr), .locked(locked),
    .err_cnt(err_cnt), .word_err(word_err)
  );

  prbs_gen_chk #(.W(8), .CNT_W(4), .LOCK_N(16), .LOSS_N(4)) u_sat (
    .clk(clk), .rst(rst), .mode(mode), .gen_en(gen_en), .inj_err(s_inj_err),
    .gen_data(s_gen_data), .gen_valid(s_gen_valid), .chk_valid(s_chk_valid),
    .chk_data(s_chk_data), .err_clr(s_err_clr), .locked(s_locked),
    .err_cnt(s_err_cnt), .word_err(s_word_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference word k of a mode, built bit by bit from the recurrence b_k = x[k-n] ^ x[k-t].
  function automatic logic [7:0] model_word(input int m, input int k);
    bit         hist[$];
    logic [7:0] w;
    int         n;
    int         t;
    n = ORD[m];
    t = TAP[m];
    w = '0;
    for (int i = 0; i < n; i++) hist.push_back(1'b1);
    for (int j = 0; j < 8 * (k + 1); j++) begin
      bit b;
      b = hist[hist.size() - n] ^ hist[hist.size() - t];
      hist.push_back(b);
      if (j >= 8 * k) w = {b, w[7:1]};
    end
    return w;
  endfunction

  task automatic do_reset(input int m);
    rst       = 1'b1;
    gen_en    = 1'b0;
    inj_err   = 1'b0;
    err_clr   = 1'b0;
    force_ff  = 1'b0;
    s_inj_err = 1'b0;
    s_err_clr = 1'b0;
    s_mask    = 8'h00;
    mode      = 2'(m);
    step();
    step();
    rst = 1'b0;
  endtask

  // Counts consumed valid words until locked rises; a timeout reports -1 words.
  task automatic wait_lock(input string tag, input int start_words, input int exp_words);
    int words;
    bit got;
    words = start_words;
    got   = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (chk_valid) words++;
      step();
      if (locked) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, got ? words : -1, exp_words);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int words;
    int bad;

    // Reset values.
    do_reset(0);
    check("rst gen_data",  gen_data,  8'h00);
    check("rst gen_valid", gen_valid, 1'b0);
    check("rst locked",    locked,    1'b0);
    check("rst word_err",  word_err,  1'b0);
    check("rst err_cnt",   err_cnt,   16'h0);

    // Each mode: first words against the model, lock latency, long error-free run.
    for (int m = 0; m < 4; m++) begin
      do_reset(m);
      gen_en = 1'b1;
      words  = 0;
      bad    = 0;
      for (int k = 0; k < 8; k++) begin
        if (chk_valid) words++;
        step();
        if (gen_data !== model_word(m, k) || gen_valid !== 1'b1) bad++;
        if (m == 0 && k == 0) begin
          check("first word", gen_data, 8'h40);
          check("first valid", gen_valid, 1'b1);
        end
        if (m == 0 && k == 1) check("second word", gen_data, 8'h30);
      end
      check($sformatf("mode%0d model words", m), bad, 0);
      wait_lock($sformatf("mode%0d lock words", m), words, LOCKW[m]);
      bad = 0;
      for (int i = 0; i < 10000; i++) begin
        step();
        if (!locked || err_cnt != 16'h0 || word_err || !s_locked || s_err_cnt != 4'h0) bad++;
      end
      check($sformatf("mode%0d clean run", m), bad, 0);
    end

    // Single injected error while locked.
    do_reset(0);
    gen_en = 1'b1;
    wait_lock("relock mode0", 0, 17);
    inj_err = 1'b1;
    step();
    inj_err = 1'b0;
    step();
    check("inj err_cnt",   err_cnt,  16'd1);
    check("inj word_err",  word_err, 1'b1);
    check("inj locked",    locked,   1'b1);
    step();
    check("inj word_err drop", word_err, 1'b0);
    check("inj err_cnt hold",  err_cnt,  16'd1);

    // LOSS_N all-ones words drop lock on the 4th, then relock unaided.
    force_ff = 1'b1;
    step();
    step();
    step();
    check("loss locked after 3", locked, 1'b1);
    step();
    check("loss locked after 4", locked, 1'b0);
    check("loss word_err",       word_err, 1'b1);
    force_ff = 1'b0;
    wait_lock("relock after loss", 0, 17);

    // Saturating 4-bit counter and err_clr behaviour on the second instance.
    check("sat locked", s_locked, 1'b1);
    s_mask = 8'hFF;
    step();
    check("sat 8",  s_err_cnt, 4'd8);
    step();
    check("sat 16", s_err_cnt, 4'd15);
    step();
    check("sat 24", s_err_cnt, 4'd15);
    s_mask = 8'h00;
    step();
    check("sat still locked", s_locked, 1'b1);
    s_mask = 8'hFF;
    step();
    step();
    step();
    check("sat no wrap", s_err_cnt, 4'd15);
    s_mask = 8'h00;
    step();
    s_mask    = 8'h01;
    s_err_clr = 1'b1;
    step();
    check("clr with 1-bit err", s_err_cnt, 4'd1);
    s_mask = 8'h00;
    step();
    check("clr clean", s_err_cnt, 4'd0);
    s_err_clr = 1'b0;
    check("sat locked end", s_locked, 1'b1);

    // Mode change while locked restarts generator from the seed.
    check("pre-change locked", locked, 1'b1);
    mode = 2'd1;
    step();
    check("mode chg locked",    locked,    1'b0);
    check("mode chg gen_valid", gen_valid, 1'b0);
    step();
    check("prbs15 word0", gen_data, 8'h00);
    words = 0;
    if (chk_valid) words++;
    step();
    check("prbs15 word1", gen_data, 8'h40);
    wait_lock("relock prbs15", words, 18);

    // Reset while locked, mode switched under reset.
    rst  = 1'b1;
    mode = 2'd0;
    step();
    check("rst locked",     locked,    1'b0);
    check("rst gen_data 2", gen_data,  8'h00);
    check("rst valid 2",    gen_valid, 1'b0);
    check("rst err_cnt 2",  err_cnt,   16'h0);
    rst = 1'b0;
    step();
    check("post-rst word", gen_data, 8'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter W, default 8: parallel bits per word, legal range 1..32.
REQ-002 SHALL have parameter CNT_W, default 16: width of the bit-error counter.
REQ-003 SHALL have parameter LOCK_N, default 16: consecutive error-free words needed to declare lock.
REQ-004 SHALL have parameter LOSS_N, default 4: consecutive errored words in LOCKED that drop lock.
REQ-005 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port mode, input, 2: polynomial select. 0=PRBS7 x^7+x^6+1, 1=PRBS15 x^15+x^14+1, 2=PRBS23 x^23+x^18+1, 3=PRBS31 x^31+x^28+1.
REQ-008 SHALL have port gen_en, input, 1: advance the generator by one word.
REQ-009 SHALL have port inj_err, input, 1: invert bit 0 of the word produced this cycle.
REQ-010 SHALL have port gen_data, output, W: generated word, registered.
REQ-011 SHALL have port gen_valid, output, 1: gen_data updated this cycle.
REQ-012 SHALL have port chk_valid, input, 1: chk_data is valid.
REQ-013 SHALL have port chk_data, input, W: word under test.
REQ-014 SHALL have port err_clr, input, 1: clear err_cnt.
REQ-015 SHALL have port locked, output, 1: checker in LOCKED.
REQ-016 SHALL have port err_cnt, output, CNT_W: saturating bit-error count.
REQ-017 SHALL have port word_err, output, 1: last checked word mismatched, registered.

Function
REQ-018 SHALL use a 31-bit LFSR s for order n and tap t of the selected mode: per bit b=s[n-1]^s[t-1]; s<={s[29:0],b}; bit emitted = b; bits above n-1 ignored.
REQ-019 SHALL emit the first generated bit of a word on bit 0, the last on bit W-1.
REQ-020 SHALL advance the generator W bits and set gen_valid=1 one cycle after gen_en=1; with gen_en=0, gen_valid=0 and gen_data holds.
REQ-021 SHALL XOR bit 0 of the output word with inj_err when gen_en=1; the LFSR state itself stays uncorrupted.
REQ-022 SHALL, on any change of mode between cycles, reload the generator seed to all ones, force the checker to SEARCH and clear locked; err_cnt is held.
REQ-023 SHALL implement checker states SEARCH, CHECK and LOCKED, advanced only when chk_valid=1.
REQ-024 SHALL, in SEARCH, shift received bits into the checker LFSR and go to CHECK once at least n bits have been loaded (ceil(n/W) words).
REQ-025 SHALL, in CHECK, predict each word from the checker LFSR, then reload it from received bits (self-synchronising).
REQ-026 SHALL, in CHECK, go to SEARCH with the counter reset on any mismatch, and go to LOCKED after LOCK_N consecutive matching words.
REQ-027 SHALL, in LOCKED, predict each word from the checker LFSR free-running, with no reload from data.
REQ-028 SHALL, in LOCKED, add popcount(predicted XOR chk_data) to err_cnt.
REQ-029 SHALL, in LOCKED, go to SEARCH after LOSS_N consecutive errored words; any clean word resets the loss count.
REQ-030 SHALL register word_err and the err_cnt update one cycle after the chk_valid word; locked SHALL change in that same cycle.
REQ-031 SHALL saturate err_cnt at all ones, with no wrap.
REQ-032 SHALL, on err_clr coincident with a counted error, load err_cnt with that word's popcount; otherwise err_clr loads 0.
REQ-033 SHALL leave err_cnt unchanged in SEARCH and CHECK.

Reset
REQ-034 SHALL, on rst=1 at a clock edge: generator LFSR all ones, checker LFSR all ones, state SEARCH, all counters 0, gen_data=0, gen_valid=0, locked=0, word_err=0, err_cnt=0.
REQ-035 SHALL give rst priority over every other input, including mid-word and mid-lock.

Verification
REQ-036 SHALL cover: W=8, mode=0, rst, then gen_en=1 -> first gen_data=0x40 and gen_valid=1 one cycle later.
REQ-037 SHALL cover: gen_data looped to chk_data in all four modes -> locked=1 after exactly ceil(n/8)+LOCK_N valid words, err_cnt stays 0 for 10000 words.
REQ-038 SHALL cover: locked loop, one inj_err pulse -> err_cnt=1, word_err high for one cycle, locked stays 1.
REQ-039 SHALL cover: locked loop, chk_data forced to 0xFF for LOSS_N words -> locked=0 after the 4th word, then relock with no other change.
REQ-040 SHALL cover: CNT_W=4, constant errors -> err_cnt saturates at 15; err_clr coincident with a 1-bit error -> err_cnt=1.
REQ-041 SHALL cover: mode change and rst while locked -> locked=0 next cycle, generator restarts from the all-ones seed.
